rf_wb_buf: RTL
==============

Name: rf_wb_buf

Overview:
Write-side driver for the 32x32 integer register file's single write port (write-address, write-data, write-enable).
- Merges two producers onto that one port:
  - the in-order pipeline writeback, which is single-cycle and never backpressured;
  - a multi-cycle result source (load/divide), which uses a valid/ready handshake.
- Multi-cycle results wait in a small FIFO and drain into idle writeback slots.
- Busy flags for decode-stage hazard stalls are derived from the pending entries.

Parameters:
DEPTH, 4, FIFO entries for multi-cycle results (power of two, 2..16)
STARVE_LIMIT, 8, consecutive pipeline-write cycles with non-empty FIFO before a forced drain slot

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
wb_we_i  in  1  pipeline writeback enable
wb_wr_i  in  5  pipeline destination register
wb_wd_i  in  32  pipeline write data
mc_valid_i  in  1  multi-cycle result valid
mc_ready_o  out  1  FIFO can accept (= not full)
mc_wr_i  in  5  multi-cycle destination register
mc_wd_i  in  32  multi-cycle result data
we_o  out  1  register-file write enable (registered)
wr_o  out  5  register-file write address (registered)
wd_o  out  32  register-file write data (registered)
rr1_i  in  5  decode read address 1
rr2_i  in  5  decode read address 2
busy1_o  out  1  rr1_i has a pending write
busy2_o  out  1  rr2_i has a pending write
stall_o  out  1  one-cycle pipeline freeze request for a forced drain
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_i=1):
  - we_o=0, wr_o=0, wd_o=0, stall_o=0, count_o=0.
  - FIFO emptied and pointers cleared; starve counter cleared.
  - Consequently mc_ready_o=1, busy1_o=0, busy2_o=0.
- Reset asserted mid-operation discards all queued entries; no partial write reaches the register file.
- Enqueue:
  - A handshake occurs when mc_valid_i & mc_ready_o at a rising edge.
  - mc_wr_i!=0: the entry is pushed.
  - mc_wr_i==0: the handshake completes but nothing is pushed (x0 writes dropped).
- mc_ready_o = (count_o != DEPTH), combinational on occupancy only.
  - When full, no enqueue occurs even if a pop happens in the same cycle.
  - mc_valid_i may stay high while waiting; data must be held stable until the handshake.
- Output slot selection each cycle, registered to we_o/wr_o/wd_o at the next edge (1-cycle latency). Priority, first match wins:
  1. stall_o=1 and FIFO non-empty: pop head. Pipeline inputs are ignored; the frozen pipeline must re-present them next cycle.
  2. wb_we_i=1 and wb_wr_i!=0: drive the pipeline write.
  3. FIFO non-empty: pop head.
  4. Otherwise: we_o<=0, wr_o/wd_o hold their previous values.
- Pipeline write to x0: treated as no write; case 3 applies.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Starve counter:
  - Increments on each cycle where case 2 is taken while the FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - On reaching STARVE_LIMIT, stall_o is registered high for exactly one cycle and the counter clears.
- Busy flags: busyN_o=1 iff rrN_i!=0 and rrN_i matches either
  - the wr field of any valid FIFO entry, or
  - wr_o while we_o=1 (the write is in flight to the register file).
  - Busy flags are combinational.
- Decode must stall any instruction whose sources or destination are busy. This guarantees a queued write never overtakes or is overtaken by a pipeline write to the same register (no WAW or RAW violation).
- Order among FIFO entries is strict FIFO.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5 and XLEN=32;
  - the FIFO entry struct {wr[4:0], wd[31:0]};
  - the output-slot source encoding {SRC_NONE, SRC_WB, SRC_MC}.
- One natural sub-module: rf_wb_fifo.
  - Contains storage, pointers, count, and per-entry valid vector with address-match outputs.
  - rf_wb_buf wraps it with arbitration, the starve counter and the output register.

Test Plan:
- Reset, then idle: rst_i pulse mid-cycle → all outputs 0 immediately, mc_ready_o=1, count_o=0. Queue 3 entries, then assert rst_i → count_o=0, we_o stays 0 afterwards.
- Pipeline only: wb_we_i=1, wb_wr_i=5, wb_wd_i=0xDEADBEEF → next cycle we_o=1, wr_o=5, wd_o=0xDEADBEEF. wb_wr_i=0 → we_o=0.
- Multi-cycle drain: push (x7, 0x11) with pipeline idle → next cycle count_o=1, busy1_o=1 for rr1_i=7. Following cycle we_o=1, wr_o=7, wd_o=0x11. busy1_o stays 1 until we_o drops.
- Full and x0 drop: push 4 entries while wb_we_i=1 to x3 every cycle (no drain) → count_o=4, mc_ready_o=0, 5th valid held. Push with mc_wr_i=0 when not full → handshake completes, count_o unchanged.
- Starvation: FIFO holds (x9, 0x22) and wb_we_i=1 continuously → after 8 pipeline writes stall_o=1 for one cycle. Next cycle we_o=1, wr_o=9, wd_o=0x22; counter cleared.
- Simultaneous push/pop with wrap: run 10 mixed push/pop cycles at DEPTH=4 → drained entries come out in push order, count_o never exceeds 4.

Source files
------------

// File: rtl/rf_wb_buf_pkg.sv
// Shared types for the register-file write-port driver: widths, the queued
// result entry and the output-slot source encoding.
package rf_wb_buf_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr;
        logic [XLEN-1:0]       wd;
    } rf_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MC   = 2'd2
    } src_t;

    // x0 is hardwired to zero, so it never counts as a pending write
    function automatic logic addr_hit(input logic [REG_ADDR_W-1:0] rr,
                                      input logic [REG_ADDR_W-1:0] wr,
                                      input logic                  vld);
        return vld && (rr != 5'd0) && (rr == wr);
    endfunction
endpackage

// File: rtl/rf_wb_buf_if.sv
// Bundle of pipeline writeback, multi-cycle handshake, register-file write
// port and decode hazard signals around rf_wb_buf.
interface rf_wb_buf_if #(parameter int DEPTH = 4) ();
    import rf_wb_buf_pkg::*;

    logic                    wb_we_i;
    logic [REG_ADDR_W-1:0]   wb_wr_i;
    logic [XLEN-1:0]         wb_wd_i;
    logic                    mc_valid_i;
    logic                    mc_ready_o;
    logic [REG_ADDR_W-1:0]   mc_wr_i;
    logic [XLEN-1:0]         mc_wd_i;
    logic                    we_o;
    logic [REG_ADDR_W-1:0]   wr_o;
    logic [XLEN-1:0]         wd_o;
    logic [REG_ADDR_W-1:0]   rr1_i;
    logic [REG_ADDR_W-1:0]   rr2_i;
    logic                    busy1_o;
    logic                    busy2_o;
    logic                    stall_o;
    logic [$clog2(DEPTH):0]  count_o;

    modport master (
        output wb_we_i, wb_wr_i, wb_wd_i, mc_valid_i, mc_wr_i, mc_wd_i, rr1_i, rr2_i,
        input  mc_ready_o, we_o, wr_o, wd_o, busy1_o, busy2_o, stall_o, count_o
    );

    modport slave (
        input  wb_we_i, wb_wr_i, wb_wd_i, mc_valid_i, mc_wr_i, mc_wd_i, rr1_i, rr2_i,
        output mc_ready_o, we_o, wr_o, wd_o, busy1_o, busy2_o, stall_o, count_o
    );
endinterface

// File: rtl/rf_wb_fifo.sv
// Queue of pending multi-cycle results with per-entry valid bits so decode
// can see which destination registers still have a write outstanding.
module rf_wb_fifo
    import rf_wb_buf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  rf_entry_t                   push_entry_i,
    input  logic                        pop_i,
    output rf_entry_t                   head_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        empty_o,
    output logic                        full_o,
    input  logic [REG_ADDR_W-1:0]       rr1_i,
    input  logic [REG_ADDR_W-1:0]       rr2_i,
    output logic                        match1_o,
    output logic                        match2_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rf_entry_t          mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               match1_s;
    logic               match2_s;

    // Storage, pointers and occupancy; the caller never pushes when full or pops when empty
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            valid_r  <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (pop_i) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + 1'b1;
            end
            if (push_i) begin
                mem_r[wr_ptr_r]   <= push_entry_i;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Address match of both decode read ports against every queued entry
    always_comb begin
        match1_s = 1'b0;
        match2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match1_s = match1_s | addr_hit(rr1_i, mem_r[i].wr, valid_r[i]);
            match2_s = match2_s | addr_hit(rr2_i, mem_r[i].wr, valid_r[i]);
        end
    end

    assign head_o   = mem_r[rd_ptr_r];
    assign count_o  = count_r;
    assign empty_o  = (count_r == '0);
    assign full_o   = (count_r == CW'(DEPTH));
    assign match1_o = match1_s;
    assign match2_o = match2_s;
endmodule

// File: rtl/rf_wb_buf.sv
// Register-file write-port driver: merges pipeline writeback with queued
// multi-cycle results, forcing a drain slot when the queue is starved.
module rf_wb_buf
    import rf_wb_buf_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    rf_wb_buf_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    rf_entry_t              head_s;
    rf_entry_t              push_entry_s;
    logic [$clog2(DEPTH):0] count_s;
    logic                   empty_s;
    logic                   full_s;
    logic                   match1_s;
    logic                   match2_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   wb_hit_s;
    src_t                   src_s;

    logic                   we_r;
    logic [REG_ADDR_W-1:0]  wr_r;
    logic [XLEN-1:0]        wd_r;
    logic                   stall_r;
    logic [SW-1:0]          starve_r;

    // x0 results complete the handshake but are never queued
    assign push_s            = bus.mc_valid_i && !full_s && (bus.mc_wr_i != 5'd0);
    assign push_entry_s.wr   = bus.mc_wr_i;
    assign push_entry_s.wd   = bus.mc_wd_i;
    assign wb_hit_s          = bus.wb_we_i && (bus.wb_wr_i != 5'd0);

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .head_o       (head_s),
        .count_o      (count_s),
        .empty_o      (empty_s),
        .full_o       (full_s),
        .rr1_i        (bus.rr1_i),
        .rr2_i        (bus.rr2_i),
        .match1_o     (match1_s),
        .match2_o     (match2_s)
    );

    // Slot arbitration: forced drain, then pipeline, then opportunistic drain
    always_comb begin
        if (stall_r && !empty_s) begin
            src_s = SRC_MC;
        end else if (wb_hit_s) begin
            src_s = SRC_WB;
        end else if (!empty_s) begin
            src_s = SRC_MC;
        end else begin
            src_s = SRC_NONE;
        end
    end

    assign pop_s = (src_s == SRC_MC);

    // Registered write port; address and data hold when no write is issued
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_r <= 1'b0;
            wr_r <= '0;
            wd_r <= '0;
        end else begin
            case (src_s)
                SRC_WB: begin
                    we_r <= 1'b1;
                    wr_r <= bus.wb_wr_i;
                    wd_r <= bus.wb_wd_i;
                end
                SRC_MC: begin
                    we_r <= 1'b1;
                    wr_r <= head_s.wr;
                    wd_r <= head_s.wd;
                end
                default: begin
                    we_r <= 1'b0;
                end
            endcase
        end
    end

    // Starve counter: pipeline slots taken while results wait, one-cycle freeze at the limit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_r <= '0;
            stall_r  <= 1'b0;
        end else if (pop_s || empty_s) begin
            starve_r <= '0;
            stall_r  <= 1'b0;
        end else if (src_s == SRC_WB) begin
            if (starve_r == SW'(STARVE_LIMIT - 1)) begin
                starve_r <= '0;
                stall_r  <= 1'b1;
            end else begin
                starve_r <= starve_r + 1'b1;
                stall_r  <= 1'b0;
            end
        end else begin
            stall_r <= 1'b0;
        end
    end

    assign bus.mc_ready_o = !full_s;
    assign bus.we_o       = we_r;
    assign bus.wr_o       = wr_r;
    assign bus.wd_o       = wd_r;
    assign bus.stall_o    = stall_r;
    assign bus.count_o    = count_s;
    assign bus.busy1_o    = match1_s || addr_hit(bus.rr1_i, wr_r, we_r);
    assign bus.busy2_o    = match2_s || addr_hit(bus.rr2_i, wr_r, we_r);
endmodule
